// File: rtl/timer_tick_pkg.sv
// Shared types and timer register constants for the timer tick servicer.
// The readback states are used only when TIMER_TICK_READBACK_EN is defined.
package timer_tick_pkg;

  typedef enum logic [2:0] {
    INIT     = 3'd0,
    IDLE     = 3'd1,
    CLEAR    = 3'd2,
    SETTLE   = 3'd3,
    RB_ADDR  = 3'd4,
    RB_CHECK = 3'd5
  } state_t;

  localparam logic [2:0]  ADDR_STATUS  = 3'd0;
  localparam logic [2:0]  ADDR_CONTROL = 3'd1;
  localparam logic [15:0] CTRL_ITO     = 16'h0001;

endpackage

// File: rtl/tick_sec_counter.sv
// Sub-second tick counter and seconds counter, advanced by one inc strobe.
// The pulse outputs are registered so that they line up with the new count values.
module tick_sec_counter #(
  parameter int TICKS_PER_SEC = 100,
  parameter int TICK_W        = 7,
  parameter int SEC_W         = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  output logic [TICK_W-1:0] tick_count,
  output logic [SEC_W-1:0]  sec_count,
  output logic              tick_pulse,
  output logic              sec_pulse
);

  logic at_last_tick;

  assign at_last_tick = (tick_count == TICK_W'(TICKS_PER_SEC - 1));

  // sec_count wraps naturally modulo 2**SEC_W
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_count <= '0;
      sec_count  <= '0;
      tick_pulse <= 1'b0;
      sec_pulse  <= 1'b0;
    end else begin
      tick_pulse <= inc;
      sec_pulse  <= inc && at_last_tick;
      if (inc) begin
        if (at_last_tick) begin
          tick_count <= '0;
          sec_count  <= sec_count + SEC_W'(1);
        end else begin
          tick_count <= tick_count + TICK_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/timer_tick_servicer.sv
// Avalon-MM master that enables the interval timer irq, clears each timeout and counts ticks.
// Define TIMER_TICK_READBACK_EN to verify the clear by reading the status register back.
module timer_tick_servicer
  import timer_tick_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100,
  parameter int TICK_W        = 7,
  parameter int SEC_W         = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              timer_irq,
  input  logic [15:0]       timer_readdata,
  output logic [2:0]        timer_address,
  output logic              timer_chipselect,
  output logic              timer_write_n,
  output logic [15:0]       timer_writedata,
  output logic              tick_pulse,
  output logic [TICK_W-1:0] tick_count,
  output logic [SEC_W-1:0]  sec_count,
  output logic              sec_pulse,
  output logic              busy
`ifdef TIMER_TICK_READBACK_EN
  ,
  output logic              clr_err
`endif
);

  state_t      state;
  state_t      next_state;
  logic        wr_next;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        inc;

`ifdef TIMER_TICK_READBACK_EN
  logic rb_bit;
  logic set_err;
`else
  logic unused_readdata;
  assign unused_readdata = ^timer_readdata;
`endif

  // Bus outputs are registered, so the decision to write is made on the
  // transition into the state that owns the write cycle.
  always_comb begin
    next_state = state;
    wr_next    = 1'b0;
    wr_addr    = ADDR_STATUS;
    wr_data    = 16'h0000;
    inc        = 1'b0;
`ifdef TIMER_TICK_READBACK_EN
    set_err    = 1'b0;
`endif
    case (state)
      INIT: begin
        wr_next    = 1'b1;
        wr_addr    = ADDR_CONTROL;
        wr_data    = CTRL_ITO;
        next_state = IDLE;
      end
      IDLE: begin
        if (timer_irq) begin
          wr_next    = 1'b1;
          wr_addr    = ADDR_STATUS;
          wr_data    = 16'h0000;
          inc        = 1'b1;
          next_state = CLEAR;
        end
      end
      CLEAR: begin
        next_state = SETTLE;
      end
      SETTLE: begin
`ifdef TIMER_TICK_READBACK_EN
        next_state = RB_ADDR;
`else
        next_state = IDLE;
`endif
      end
`ifdef TIMER_TICK_READBACK_EN
      RB_ADDR: begin
        next_state = RB_CHECK;
      end
      RB_CHECK: begin
        if (rb_bit) begin
          // Timeout flag survived the clear: retry without counting a tick
          wr_next    = 1'b1;
          wr_addr    = ADDR_STATUS;
          wr_data    = 16'h0000;
          set_err    = 1'b1;
          next_state = CLEAR;
        end else begin
          next_state = IDLE;
        end
      end
`endif
      default: begin
        next_state = INIT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= INIT;
      timer_address    <= 3'd0;
      timer_chipselect <= 1'b0;
      timer_write_n    <= 1'b1;
      timer_writedata  <= 16'h0000;
      busy             <= 1'b1;
    end else begin
      state            <= next_state;
      timer_chipselect <= wr_next;
      timer_write_n    <= ~wr_next;
      timer_address    <= wr_next ? wr_addr : 3'd0;
      timer_writedata  <= wr_next ? wr_data : 16'h0000;
      busy             <= (next_state != IDLE);
    end
  end

`ifdef TIMER_TICK_READBACK_EN
  // Status read data is registered in the timer, so it is valid while in RB_ADDR
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rb_bit  <= 1'b0;
      clr_err <= 1'b0;
    end else begin
      if (state == RB_ADDR) begin
        rb_bit <= timer_readdata[0];
      end
      if (set_err) begin
        clr_err <= 1'b1;
      end
    end
  end
`endif

  tick_sec_counter #(
    .TICKS_PER_SEC(TICKS_PER_SEC),
    .TICK_W       (TICK_W),
    .SEC_W        (SEC_W)
  ) u_counter (
    .clk       (clk),
    .reset     (reset),
    .inc       (inc),
    .tick_count(tick_count),
    .sec_count (sec_count),
    .tick_pulse(tick_pulse),
    .sec_pulse (sec_pulse)
  );

endmodule

// File: tb/tb_timer_tick_servicer.sv
// Self-checking bench for timer_tick_servicer: timeline model plus literal checkpoints.
// Small parameters (5 ticks per second, 4-bit seconds) make the seconds wrap reachable.
module tb_timer_tick_servicer;

  localparam int TPS = 5;
  localparam int TW  = 3;
  localparam int SW  = 4;

  logic          clk;
  logic          reset;
  logic          timer_irq;
  logic [15:0]   timer_readdata;
  logic [2:0]    timer_address;
  logic          timer_chipselect;
  logic          timer_write_n;
  logic [15:0]   timer_writedata;
  logic          tick_pulse;
  logic [TW-1:0] tick_count;
  logic [SW-1:0] sec_count;
  logic          sec_pulse;
  logic          busy;
`ifdef TIMER_TICK_READBACK_EN
  logic          clr_err;
`endif

  int assert_cnt = 0;
  int fail_cnt   = 0;
  int tick_seen  = 0;
  int sec_seen   = 0;

  // Model state: a timeline of clock edges since reset release
  bit model_valid = 1'b0;
  int edge_idx;
  int ready_edge;
  int ticks_total;
  int m_cs, m_addr, m_wd, m_tick, m_sec, m_busy;

  timer_tick_servicer #(
    .TICKS_PER_SEC(TPS),
    .TICK_W       (TW),
    .SEC_W        (SW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .timer_irq       (timer_irq),
    .timer_readdata  (timer_readdata),
    .timer_address   (timer_address),
    .timer_chipselect(timer_chipselect),
    .timer_write_n   (timer_write_n),
    .timer_writedata (timer_writedata),
    .tick_pulse      (tick_pulse),
    .tick_count      (tick_count),
    .sec_count       (sec_count),
    .sec_pulse       (sec_pulse),
    .busy            (busy)
`ifdef TIMER_TICK_READBACK_EN
    ,
    .clr_err         (clr_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    assert_cnt++;
    if (actual != expected) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Edge 1 after release issues the enable write; an irq seen at an edge
  // at or after ready_edge is serviced, with a write and tick in the next
  // cycle, and the next irq can be taken three edges later.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_idx    = 0;
      ready_edge  = 2;
      ticks_total = 0;
      m_cs = 0; m_addr = 0; m_wd = 0; m_tick = 0; m_sec = 0; m_busy = 1;
      model_valid = 1'b1;
    end else begin
      edge_idx++;
      m_cs = 0; m_addr = 0; m_wd = 0; m_tick = 0; m_sec = 0;
      if (edge_idx == 1) begin
        m_cs = 1; m_addr = 1; m_wd = 16'h0001; m_busy = 0;
      end else if (edge_idx >= ready_edge && timer_irq) begin
        ticks_total++;
        m_cs = 1; m_tick = 1; m_busy = 1;
        m_sec = (ticks_total % TPS == 0) ? 1 : 0;
        ready_edge = edge_idx + 3;
      end else begin
        m_busy = (edge_idx < ready_edge - 1) ? 1 : 0;
      end
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      checkOutput("chipselect", int'(timer_chipselect), m_cs);
      checkOutput("write_n", int'(timer_write_n), 1 - m_cs);
      checkOutput("address", int'(timer_address), m_addr);
      checkOutput("writedata", int'(timer_writedata), m_wd);
      checkOutput("tick_pulse", int'(tick_pulse), m_tick);
      checkOutput("sec_pulse", int'(sec_pulse), m_sec);
      checkOutput("busy", int'(busy), m_busy);
      checkOutput("tick_count", int'(tick_count), ticks_total % TPS);
      checkOutput("sec_count", int'(sec_count), (ticks_total / TPS) % (1 << SW));
      if (tick_pulse) tick_seen++;
      if (sec_pulse) sec_seen++;
    end
  end

  // One irq sampled high at exactly one edge, then gap idle cycles
  task automatic applyStimulus(input int gap);
    @(negedge clk);
    timer_irq = 1'b1;
    @(negedge clk);
    timer_irq = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  int tick_base;

  initial begin
    reset          = 1'b0;
    timer_irq      = 1'b0;
    timer_readdata = 16'h0000;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_chipselect", int'(timer_chipselect), 0);
    checkOutput("rst_write_n", int'(timer_write_n), 1);
    checkOutput("rst_busy", int'(busy), 1);
    checkOutput("rst_tick_count", int'(tick_count), 0);
    reset = 1'b0;

    @(negedge clk);
    checkOutput("init_address", int'(timer_address), 1);
    checkOutput("init_writedata", int'(timer_writedata), 16'h0001);
    repeat (2) @(negedge clk);
    checkOutput("idle_busy", int'(busy), 0);

    applyStimulus(3);
    checkOutput("first_tick_count", int'(tick_count), 1);

    for (int i = 2; i <= 80; i++) begin
      applyStimulus(2 + (i % 3));
      if (i == 5) begin
        checkOutput("sec1_tick_count", int'(tick_count), 0);
        checkOutput("sec1_sec_count", int'(sec_count), 1);
      end
    end
    checkOutput("wrap_sec_count", int'(sec_count), 0);
    checkOutput("wrap_sec_pulses", sec_seen, 16);

    tick_base = tick_seen;
    @(negedge clk);
    timer_irq = 1'b1;
    repeat (30) @(negedge clk);
    timer_irq = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("stuck_ticks", tick_seen - tick_base, 10);
    checkOutput("stuck_sec_count", int'(sec_count), 2);

    timer_irq = 1'b1;
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    checkOutput("midwr_chipselect", int'(timer_chipselect), 0);
    checkOutput("midwr_write_n", int'(timer_write_n), 1);
    checkOutput("midwr_tick_count", int'(tick_count), 0);
    checkOutput("midwr_sec_count", int'(sec_count), 0);
    @(negedge clk);
    timer_irq = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reinit_chipselect", int'(timer_chipselect), 1);
    checkOutput("reinit_address", int'(timer_address), 1);
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
